// File: rtl/product_acc_pkg.sv
// Shared mode encodings, FSM state type and default lane width for product_accumulator.
// Pure declarations; no logic, latency or flow control here.
package product_acc_pkg;

  localparam int LANE_W_DEF = 20;

  localparam logic [1:0] MODE_S8  = 2'b00;
  localparam logic [1:0] MODE_D8  = 2'b01;
  localparam logic [1:0] MODE_S16 = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_adder.sv
// Unsigned a+b clamped to 2^W-1 with a saturation flag; purely combinational, no backpressure.
// The carry out of a W+1 bit sum is exactly the overflow condition.
module sat_adder #(
  parameter int W = 20
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_sat
);

  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_sat  = w_full[W];
  assign o_sum  = w_full[W] ? {W{1'b1}} : w_full[W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums a frame of multiplier products (single/dual 8x8 lanes or 16x16); result valid 1 cycle after last product.
// Result is held under valid/ready until accepted; products arriving outside a frame are dropped and flagged.
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [1:0]          cm_i,
  input  logic [CNT_W-1:0]    frame_len_i,
  input  logic [31:0]         product_i,
  input  logic                product_valid_i,
  output logic                mul_enable_o,
  output logic [2*LANE_W-1:0] result_o,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic                sat_o,
  output logic                drop_o,
  output logic                mode_err_o,
  output logic                busy_o
);

  localparam int ACC_W = 2 * LANE_W;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_mode;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_sat;
  logic               r_drop;
  logic               r_mode_err;
  logic               r_mul_en;
  logic               r_res_vld;

  logic               w_start;
  logic               w_start_rsv;
  logic               w_abort;
  logic               w_take;
  logic               w_last;
  logic               w_hs;

  logic [LANE_W-1:0]  w_sum0;
  logic [LANE_W-1:0]  w_sum1;
  logic [ACC_W-1:0]   w_sumw;
  logic               w_sat0;
  logic               w_sat1;
  logic               w_satw;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic               w_sat_nxt;

  assign w_start     = (r_state == IDLE) && start_i && (cm_i != MODE_RSV);
  assign w_start_rsv = (r_state == IDLE) && start_i && (cm_i == MODE_RSV);
  assign w_abort     = (r_state != IDLE) && abort_i;
  assign w_take      = (r_state == ACCUM) && product_valid_i && !abort_i;
  assign w_last      = w_take && (r_cnt == '0);
  assign w_hs        = (r_state == HOLD) && r_res_vld && result_ready_i && !abort_i;

  sat_adder #(.W(LANE_W)) u_lane0 (
    .i_a   (r_acc[LANE_W-1:0]),
    .i_b   (LANE_W'(product_i[15:0])),
    .o_sum (w_sum0),
    .o_sat (w_sat0)
  );

  sat_adder #(.W(LANE_W)) u_lane1 (
    .i_a   (r_acc[ACC_W-1:LANE_W]),
    .i_b   (LANE_W'(product_i[31:16])),
    .o_sum (w_sum1),
    .o_sat (w_sat1)
  );

  sat_adder #(.W(ACC_W)) u_wide (
    .i_a   (r_acc),
    .i_b   (ACC_W'(product_i)),
    .o_sum (w_sumw),
    .o_sat (w_satw)
  );

  // Lane results share the wide register: lane1 in the upper half, lane0 in the lower.
  always_comb begin
    w_acc_nxt = r_acc;
    w_sat_nxt = 1'b0;
    case (r_mode)
      MODE_S8: begin
        w_acc_nxt = {r_acc[ACC_W-1:LANE_W], w_sum0};
        w_sat_nxt = w_sat0;
      end
      MODE_D8: begin
        w_acc_nxt = {w_sum1, w_sum0};
        w_sat_nxt = w_sat0 | w_sat1;
      end
      MODE_S16: begin
        w_acc_nxt = w_sumw;
        w_sat_nxt = w_satw;
      end
      default: begin
        w_acc_nxt = r_acc;
        w_sat_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = ACCUM;
      end
      ACCUM: begin
        if (abort_i)     w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (abort_i)   w_state_nxt = IDLE;
        else if (w_hs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_mode     <= MODE_S8;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_sat      <= 1'b0;
      r_mode_err <= 1'b0;
      r_mul_en   <= 1'b0;
      r_res_vld  <= 1'b0;
    end else begin
      r_mode_err <= w_start_rsv;
      if (w_start) begin
        r_mode    <= cm_i;
        r_cnt     <= frame_len_i - CNT_W'(1);
        r_acc     <= '0;
        r_sat     <= 1'b0;
        r_mul_en  <= 1'b1;
        r_res_vld <= 1'b0;
      end else if (w_abort) begin
        r_acc     <= '0;
        r_mul_en  <= 1'b0;
        r_res_vld <= 1'b0;
      end else begin
        if (w_take) begin
          r_acc <= w_acc_nxt;
          r_sat <= r_sat | w_sat_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_mul_en  <= 1'b0;
            r_res_vld <= 1'b1;
          end
        end
        if (w_hs) r_res_vld <= 1'b0;
      end
    end
  end

  // A product coinciding with start is dropped after the start-time clear.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_drop <= 1'b0;
    end else if (w_start) begin
      r_drop <= product_valid_i;
    end else if (product_valid_i && (r_state != ACCUM)) begin
      r_drop <= 1'b1;
    end
  end

  assign mul_enable_o   = r_mul_en;
  assign result_o       = r_acc;
  assign result_valid_o = r_res_vld;
  assign sat_o          = r_sat;
  assign drop_o         = r_drop;
  assign mode_err_o     = r_mode_err;
  assign busy_o         = (r_state != IDLE);

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream stage of configurable_multiplication; consumes its product word and valid pulse.
- Accumulates a frame of N products per the multiplier's mode: one 8x8 lane, two parallel 8x8 lanes, or one 16x16.
- Drives the multiplier's enable while a frame is open.
- Presents the frame sum through a valid/ready handshake.

Parameters:
- LANE_W, 20: width of each 8x8-mode lane accumulator; ACC_W = 2*LANE_W is a derived localparam.
- CNT_W, 8: frame-length counter width.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous active-low reset.
- start_i  in  1  open a frame (sampled in IDLE only).
- abort_i  in  1  discard the current frame.
- cm_i  in  2  mode, latched at start: 00 single 8x8, 01 dual 8x8, 10 single 16x16, 11 reserved.
- frame_len_i  in  CNT_W  products per frame, latched at start; 0 means 2^CNT_W.
- product_i  in  32  product16x16_o from the multiplier.
- product_valid_i  in  1  data_valid_o from the multiplier.
- mul_enable_o  out  1  enable_i to the multiplier.
- result_o  out  ACC_W  frame sum: {lane1,lane0} in dual mode; {0,lane0} in single 8x8 mode; full ACC_W value in 16x16 mode.
- result_valid_o  out  1  result held valid.
- result_ready_i  in  1  consumer accepts.
- sat_o  out  1  sticky per frame: some lane or accumulator saturated.
- drop_o  out  1  sticky per frame: product_valid_i arrived outside ACCUM.
- mode_err_o  out  1  start attempted with cm_i=11.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: async assert clears all state. State=IDLE; every output 0; accumulators, counter and sticky flags 0.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - start_i with cm_i!=11 goes to ACCUM: latch mode and length; clear accumulators, sat_o, drop_o and mode_err_o.
  - start_i with cm_i=11 stays in IDLE and sets mode_err_o for exactly one cycle.
  - product_valid_i in IDLE sets drop_o and is otherwise ignored.
- ACCUM:
  - mul_enable_o=1 (registered, high from the first ACCUM cycle).
  - Each product_valid_i cycle adds the product and decrements the remaining count. Unsigned arithmetic:
    - 00: lane0 += product_i[15:0].
    - 01: lane1 += product_i[31:16] and lane0 += product_i[15:0], independently.
    - 10: acc += zero-extended product_i[31:0].
  - Saturating adds: a lane clamps at 2^LANE_W-1 (acc clamps at 2^ACC_W-1) and sets sat_o. One dual-mode lane saturating leaves the other lane unaffected.
  - On the edge that accepts the last product: go to HOLD, drop mul_enable_o. result_valid_o is high in the next cycle (1-cycle latency from the last valid).
  - cm_i / frame_len_i changes during ACCUM are ignored.
- HOLD:
  - result_o and result_valid_o are stable until result_valid_o && result_ready_i; that cycle goes to IDLE.
  - result_o keeps its value in IDLE until the next start.
  - product_valid_i in HOLD sets drop_o.
  - start_i outside IDLE is ignored.
- abort_i in ACCUM or HOLD:
  - Goes to IDLE next edge; result_valid_o=0; mul_enable_o=0; accumulators cleared.
  - abort_i wins over a simultaneous last product_valid_i or result_ready_i.
- In IDLE, simultaneous start_i and product_valid_i: the frame opens and the product is dropped (drop_o is set after the start clear).
- Counter: loads frame_len_i-1 at start (0 loads all-ones, giving 2^CNT_W products); the last product is accepted when the count is 0.

Decomposition:
- Package product_acc_pkg holds:
  - mode encodings MODE_S8=2'b00, MODE_D8=2'b01, MODE_S16=2'b10, MODE_RSV=2'b11;
  - state enum IDLE/ACCUM/HOLD;
  - the default LANE_W.
- Sub-module sat_adder (parameter W): unsigned a+b clamped to 2^W-1, plus a sat flag. Instantiated twice at LANE_W for the lanes and once at ACC_W for 16x16 mode; the lane registers are muxed onto the wide register.

Test Plan:
- Dual mode, len 3, product {0x7E8B,0x3633} x3 -> result_o={0x17BA1,0x0A299}; result_valid_o 1 cycle after the 3rd valid; sat_o=0.
- 16x16 mode, len 2, product 0x7F387433 x2 -> result_o=0x00FE70E866; mul_enable_o falls with the last accept.
- Dual mode saturation: len 17, product {0xFE01,0x0001} x17 -> lane1=0xFFFFF, lane0=0x00011, sat_o=1.
- Handshake hold: result_ready_i=0 for 5 cycles, then 1 -> result_o stable throughout; IDLE after the ready cycle; an extra product_valid_i in HOLD -> drop_o=1.
- Abort after 2 of 4 products, then a new frame in single 8x8 mode, len 1, product 0x0000_00FF -> no result for the aborted frame; new result_o=0x00000000FF.
- cm_i=11 start -> stays IDLE, mode_err_o pulses 1 cycle. Reset asserted mid-ACCUM -> all outputs 0 immediately (asynchronously).
